sqrt_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one sequential integer square-root core (16-bit operand, 8-bit root, done flag) among N_REQ requesters. It accepts operands over per-requester valid/ready handshakes and launches the core with a one-cycle active-low start pulse. It waits for the core's done flag and returns the root, tagged with the requester ID, on a single response channel. It sits between the core and its client blocks; the core is never driven directly by clients.

---
 rtl/sqrt_rr_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_sqrt_rr_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_rr_scheduler.sv
// sqrt_rr_scheduler: round-robin front end that shares one sequential
// integer square-root core among N_REQ requesters.
// Requests are granted from IDLE and the core is started with a one-cycle
// active-low pulse. The root, tagged with the requester ID, is returned on
// a single response channel. A core that never finishes is aborted after
// TIMEOUT cycles in RUN, and the response is flagged as an error.
// Optional build macro: SQRT_SCHED_STATS_EN adds completion and
// max-latency statistics outputs.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | arbitrate; a grant latches the operand and the ID
// LAUNCH | core_start_n_o low for this single cycle
// ARM    | give the core one cycle to drop its done flag; clear counter
// RUN    | wait for core done or timeout; capture the result
// RESP   | present the response until the consumer accepts it
module sqrt_rr_scheduler #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid_i,
    output logic [N_REQ-1:0]     req_ready_o,
    input  logic [16*N_REQ-1:0]  req_value_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [ID_W-1:0]      rsp_id_o,
    output logic [7:0]           rsp_root_o,
    output logic                 rsp_err_o,
    output logic [15:0]          core_valor_o,
    output logic                 core_start_n_o,
    input  logic                 core_ready_i,
    input  logic [7:0]           core_root_i,
    output logic                 busy_o
`ifdef SQRT_SCHED_STATS_EN
    ,
    output logic [15:0]          stat_done_o,
    output logic [10:0]          stat_maxlat_o
`endif
);

    // Counter is at least 11 bits so the RUN cycle count fits the stats width.
    localparam int CNT_W = ($clog2(TIMEOUT) > 11) ? $clog2(TIMEOUT) : 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_ARM,
        S_RUN,
        S_RESP
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   ptr_nxt;
    logic [ID_W-1:0]   id_q;
    logic [15:0]       opnd_q;
    logic [7:0]        root_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              gnt_any;
    logic [ID_W-1:0]   gnt_id;
    logic              run_timeout;
    int                idx;

    // Round-robin search starting at ptr_q, wrapping modulo N_REQ.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr_q) + i) % N_REQ;
            if (!gnt_any && req_valid_i[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
        ptr_nxt = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end

    assign run_timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d        = state_q;
        req_ready_o    = '0;
        core_start_n_o = 1'b1;
        rsp_valid_o    = 1'b0;
        busy_o         = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (gnt_any) begin
                    req_ready_o = N_REQ'(1) << gnt_id;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                core_start_n_o = 1'b0;
                state_d        = S_ARM;
            end
            S_ARM: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (core_ready_i || run_timeout) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath: operand/ID capture on grant, RUN counter, result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            id_q   <= '0;
            opnd_q <= '0;
            root_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_any) begin
                        opnd_q <= req_value_i[16*int'(gnt_id) +: 16];
                        id_q   <= gnt_id;
                        ptr_q  <= ptr_nxt;
                    end
                end
                S_ARM: begin
                    cnt_q <= '0;
                end
                S_RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // A done flag in the timeout cycle still delivers the root.
                    if (core_ready_i) begin
                        root_q <= core_root_i;
                        err_q  <= 1'b0;
                    end else if (run_timeout) begin
                        root_q <= '0;
                        err_q  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign core_valor_o = opnd_q;
    assign rsp_id_o     = id_q;
    assign rsp_root_o   = root_q;
    assign rsp_err_o    = err_q;

`ifdef SQRT_SCHED_STATS_EN
    logic [10:0] lat_q;

    // Statistics: completed responses and worst non-error RUN length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q         <= '0;
            stat_done_o   <= '0;
            stat_maxlat_o <= '0;
        end else begin
            if (state_q == S_RUN && core_ready_i) begin
                lat_q <= cnt_q[10:0] + 11'd1;
            end
            if (state_q == S_RESP && rsp_ready_i) begin
                stat_done_o <= stat_done_o + 16'd1;
                if (!err_q && lat_q > stat_maxlat_o) begin
                    stat_maxlat_o <= lat_q;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sqrt_rr_scheduler.sv
// Testbench for sqrt_rr_scheduler: random and directed stimulus, a
// behavioural core model, and a scoreboard checked by a separate monitor.
module tb_sqrt_rr_scheduler;

    localparam int N  = 4;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [16*N-1:0]   req_value = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [1:0]        rsp_id;
    logic [7:0]        rsp_root;
    logic              rsp_err;
    logic [15:0]       core_valor;
    logic              core_start_n;
    logic              core_ready = 1'b1;
    logic [7:0]        core_root = '0;
    logic              busy;
`ifdef SQRT_SCHED_STATS_EN
    logic [15:0]       stat_done;
    logic [10:0]       stat_maxlat;
`endif

    sqrt_rr_scheduler #(.N_REQ(N), .ID_W(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_value_i(req_value),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_root_o(rsp_root), .rsp_err_o(rsp_err),
        .core_valor_o(core_valor), .core_start_n_o(core_start_n),
        .core_ready_i(core_ready), .core_root_i(core_root), .busy_o(busy)
`ifdef SQRT_SCHED_STATS_EN
        , .stat_done_o(stat_done), .stat_maxlat_o(stat_maxlat)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] root;
        logic       err;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [15:0] pend [N][$];
    exp_t        sb [$];
    int          rsp_log [$];
    int          m_ptr = 0;
    bit          m_busy = 0;
    bit          start_due = 0;
    bit          rsp_first = 0;
    int          cyc_start = 0;
    bit          hold = 0;
    bit          bp_rand = 0;
    bit          drop_en = 0;
    bit          core_hang = 0;
    int          core_lat_force = 0;
    int          core_lat = 1;
    int          core_next = 3;
    int          core_cnt = 0;
    logic [15:0] core_op = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference root: largest r with r*r <= v.
    function automatic int ref_sqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic issue(input int k, input logic [15:0] v);
        pend[k].push_back(v);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Drive requester valids/values and the response ready after each edge.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < N; k++) begin
            if (pend[k].size() > 0 && (!drop_en || ($urandom % 4) != 0)) begin
                req_valid[k] = 1'b1;
                req_value[16*k +: 16] = pend[k][0];
            end else begin
                req_valid[k] = 1'b0;
            end
        end
        rsp_ready = hold ? 1'b0 : (bp_rand ? 1'($urandom % 2) : 1'b1);
    end

    // Core model: done drops after a start pulse, rises after a latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_ready <= 1'b1;
            core_cnt   <= 0;
        end else if (!core_start_n) begin
            core_op    <= core_valor;
            core_ready <= 1'b0;
            core_lat   <= (core_lat_force != 0) ? core_lat_force : core_next;
            core_cnt   <= core_hang ? 0 : ((core_lat_force != 0) ? core_lat_force : core_next);
            core_next  <= int'($urandom_range(10, 1));
        end else if (core_cnt == 1) begin
            core_ready <= 1'b1;
            core_root  <= 8'(int'($floor($sqrt(real'(core_op)))));
            core_cnt   <= 0;
        end else if (core_cnt > 1) begin
            core_cnt <= core_cnt - 1;
        end
    end

    // Monitor: arbitration model, start pulse, busy, and response scoreboard.
    always @(negedge clk) begin
        int   exp_g;
        int   idx;
        int   exp_ready;
        exp_t e;
        logic [15:0] v;
        if (rst_n) begin
            chk("busy", 32'(busy), 32'(m_busy));
            exp_g = -1;
            if (!m_busy) begin
                for (int i = 0; i < N; i++) begin
                    idx = (m_ptr + i) % N;
                    if (exp_g < 0 && req_valid[idx]) exp_g = idx;
                end
            end
            exp_ready = (exp_g >= 0) ? (1 << exp_g) : 0;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("start_n", 32'(core_start_n), 32'(!start_due));
            if (start_due) cyc_start = cyc;
            start_due = 0;
            if (exp_g >= 0) begin
                v = pend[exp_g].pop_front();
                e.id   = 2'(exp_g);
                e.err  = core_hang;
                e.root = core_hang ? 8'd0 : 8'(ref_sqrt(int'(v)));
                sb.push_back(e);
                m_ptr     = (exp_g + 1) % N;
                m_busy    = 1;
                start_due = 1;
                rsp_first = 1;
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb[0];
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_root", 32'(rsp_root), 32'(e.root));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    if (rsp_first) begin
                        chk("latency", 32'(cyc - cyc_start), 32'(2 + (e.err ? TO : core_lat)));
                        rsp_first = 0;
                    end
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        rsp_log.push_back(int'(rsp_id));
                        m_busy = 0;
                    end
                end
            end
        end
    end

    task automatic drain(input int budget);
        int n = 0;
        while ((pend[0].size() + pend[1].size() + pend[2].size() + pend[3].size()
                + sb.size()) != 0 || m_busy) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                chk("drain_timeout", 32'(n), 32'(budget));
                return;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_rsp_root"}, 32'(rsp_root), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_core_valor"}, 32'(core_valor), 32'd0);
        chk({tag, "_core_start_n"}, 32'(core_start_n), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        logic [15:0] bvals [4];
        #1;
        check_reset_values("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request: 144 -> 12.
        issue(0, 16'd144);
        drain(200);

        // Boundary operands on random requesters.
        bvals[0] = 16'd0; bvals[1] = 16'd1; bvals[2] = 16'hFFFF; bvals[3] = 16'hFFFE;
        for (int i = 0; i < 4; i++) begin
            issue(int'($urandom_range(3, 0)), bvals[i]);
            drain(200);
        end

        // Backpressure: consumer stalls five cycles in RESP.
        hold = 1;
        issue(1, 16'd1000);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        repeat (5) @(negedge clk);
        hold = 0;
        drain(100);

        // Timeout: core never finishes; next request served normally.
        core_hang = 1;
        issue(3, 16'd2500);
        drain(300);
        core_hang = 0;
        issue(3, 16'd2500);
        drain(200);

        // Reset in RUN with requester 2 in flight.
        core_lat_force = 20;
        issue(2, 16'd400);
        n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        req_valid = '0;
        for (int k = 0; k < N; k++) pend[k].delete();
        sb.delete();
        m_ptr = 0;
        m_busy = 0;
        start_due = 0;
        rsp_first = 0;
        #1;
        check_reset_values("midrst");
        core_lat_force = 0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Fairness after reset: all valid, order must start at 0.
        rsp_log.delete();
        for (int r = 0; r < 2; r++) begin
            issue(0, 16'd4); issue(1, 16'd9); issue(2, 16'd16); issue(3, 16'd25);
        end
        drain(500);
        chk("fair_count", 32'(rsp_log.size()), 32'd8);
        for (int i = 0; i < rsp_log.size() && i < 8; i++)
            chk("fair_order", 32'(rsp_log[i]), 32'(i % 4));

        // Random traffic with valid drops and random backpressure.
        bp_rand = 1;
        drop_en = 1;
        for (int t = 0; t < 150; t++) begin
            issue(int'($urandom_range(3, 0)), 16'($urandom));
            repeat ($urandom_range(12, 0)) @(negedge clk);
        end
        drain(6000);
        bp_rand = 0;
        drop_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
